// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StIssue   = 2'd1,
      StCapture = 2'd2,
      StDone    = 2'd3
   } state_e;

   localparam int unsigned NIB_BITS = 4;
   localparam int unsigned FCLA_LAT = 1;

endpackage

// File: rtl/cla_nibble_sequencer_fcla.sv
// 4-bit carry-lookahead adder with registered sum and carry out (latency 1, no reset).
module fcla
   import cla_pkg::*;
(
   input  logic                clk,
   input  logic [NIB_BITS-1:0] a_i,
   input  logic [NIB_BITS-1:0] b_i,
   input  logic                cin_i,
   output logic [NIB_BITS-1:0] s_o,
   output logic                cout_o
);

   logic [NIB_BITS-1:0] g, p, s_d, s_q;
   logic [NIB_BITS:0]   c;
   logic                cout_q;

   always_comb begin
      g    = a_i & b_i;
      p    = a_i ^ b_i;
      c[0] = cin_i;
      c[1] = g[0] | (p[0] & cin_i);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin_i);
      s_d  = p ^ c[NIB_BITS-1:0];
   end

   always_ff @(posedge clk) begin
      s_q    <= s_d;
      cout_q <= c[NIB_BITS];
   end

   assign s_o    = s_q;
   assign cout_o = cout_q;

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder: one shared registered 4-bit CLA is fed a nibble per
// ISSUE/CAPTURE step, LSB first, with the carry chained through c_q.
module cla_nibble_sequencer
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned NIB  = WIDTH / NIB_BITS;
   localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

   if ((WIDTH % NIB_BITS) != 0 || WIDTH < NIB_BITS) begin : g_bad_width
      $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
   end
   // The ISSUE/CAPTURE pairing relies on the fcla result appearing exactly one edge later.
   if (FCLA_LAT != 1) begin : g_bad_lat
      $error("cla_nibble_sequencer: fcla latency must be 1");
   end

   state_e              state_q, state_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic                c_q, c_d;
   logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [NIB_BITS-1:0] f_a, f_b, f_s;
   logic                f_cin, f_cout;

   fcla u_fcla (
      .clk    (clk),
      .a_i    (f_a),
      .b_i    (f_b),
      .cin_i  (f_cin),
      .s_o    (f_s),
      .cout_o (f_cout)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      c_d     = c_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      f_a     = '0;
      f_b     = '0;
      f_cin   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               c_d     = cin;
               idx_d   = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            f_a     = a_q[NIB_BITS*idx_q +: NIB_BITS];
            f_b     = b_q[NIB_BITS*idx_q +: NIB_BITS];
            f_cin   = c_q;
            state_d = StCapture;
         end
         StCapture: begin
            sum_d[NIB_BITS*idx_q +: NIB_BITS] = f_s;
            c_d = f_cout;
            if (idx_q == LastIdx) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = StIssue;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         c_q     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         c_q     <= c_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign sum       = sum_q;
   assign cout      = c_q;
   assign ovf       = out_valid && (a_q[WIDTH-1] == b_q[WIDTH-1])
                                && (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule
